// File: rtl/i2s_src_arb.sv
// ---------------------------------------------------------------------------
// i2s_src_arb
// Arbitrates two stereo sample sources onto a single I2S transmitter input.
// Every decision is taken on the one-cycle frame strobe. Ownership is either
// fixed priority (source 0 wins from idle) or round robin with a burst limit.
// An owner that misses a frame produces a muted sample and an underrun pulse.
// After too many consecutive misses the owner loses the grant.
//
// Ports
//   i_clk_12_288         sole clock
//   i_reset_n            synchronous active-low reset
//   i_frame              one-cycle pulse per I2S frame
//   i_mode               0 = fixed priority, 1 = round robin
//   i_s0_valid/i_s1_valid  source has a stereo sample pending
//   i_sN_l / i_sN_r      source sample data
//   o_s0_ready/o_s1_ready  sample consumed this cycle (combinational)
//   o_audio_l/o_audio_r  registered sample towards the I2S transmitter
//   o_grant              one-hot owner, 2'b00 = none
//   o_underrun           one-cycle pulse when the owner missed a frame
//   o_underrun_cnt       saturating underrun count
// ---------------------------------------------------------------------------
module i2s_src_arb #(
   parameter int DATA_BIT     = 16,
   parameter int IDLE_FRAMES  = 4,
   parameter int BURST_FRAMES = 8
) (
   input  logic                i_clk_12_288,
   input  logic                i_reset_n,
   input  logic                i_frame,
   input  logic                i_mode,
   input  logic                i_s0_valid,
   input  logic                i_s1_valid,
   input  logic [DATA_BIT-1:0] i_s0_l,
   input  logic [DATA_BIT-1:0] i_s0_r,
   input  logic [DATA_BIT-1:0] i_s1_l,
   input  logic [DATA_BIT-1:0] i_s1_r,
   output logic                o_s0_ready,
   output logic                o_s1_ready,
   output logic [DATA_BIT-1:0] o_audio_l,
   output logic [DATA_BIT-1:0] o_audio_r,
   output logic [1:0]          o_grant,
   output logic                o_underrun,
   output logic [15:0]         o_underrun_cnt
);

   // State encoding doubles as the one-hot grant value.
   localparam logic [1:0] IDLE   = 2'b00;
   localparam logic [1:0] GRANT0 = 2'b01;
   localparam logic [1:0] GRANT1 = 2'b10;

   logic [1:0]          state;
   logic                last_granted;   // 0 = source 0, 1 = source 1
   logic [3:0]          miss_cnt;
   logic [7:0]          burst_cnt;

   logic                owner_is_s1;
   logic                owner_valid;
   logic                other_valid;
   logic [DATA_BIT-1:0] owner_l;
   logic [DATA_BIT-1:0] owner_r;
   logic [8:0]          burst_next;
   logic [4:0]          miss_next;
   logic                burst_done;
   logic                pref_valid;
   logic                idle_pick_s1;

   // Owner-relative views so the grant states share one code path.
   always_comb begin
      owner_is_s1 = (state == GRANT1);
      owner_valid = owner_is_s1 ? i_s1_valid : i_s0_valid;
      other_valid = owner_is_s1 ? i_s0_valid : i_s1_valid;
      owner_l     = owner_is_s1 ? i_s1_l : i_s0_l;
      owner_r     = owner_is_s1 ? i_s1_r : i_s0_r;
      burst_next  = {1'b0, burst_cnt} + 9'd1;
      miss_next   = {1'b0, miss_cnt} + 5'd1;
      // >= rather than == so a mode change after a long fixed-priority
      // grant still yields at the next transfer.
      burst_done  = i_mode && (burst_next >= 9'(BURST_FRAMES));
      // Round robin prefers whichever source was not granted last.
      pref_valid   = last_granted ? i_s0_valid : i_s1_valid;
      idle_pick_s1 = i_mode ? (pref_valid ? ~last_granted : last_granted)
                            : ~i_s0_valid;
   end

   // Ready is gated by reset so a reset mid-grant never shows a consume.
   assign o_s0_ready = i_reset_n & i_frame & (state == GRANT0);
   assign o_s1_ready = i_reset_n & i_frame & (state == GRANT1);
   assign o_grant    = state;

   always_ff @(posedge i_clk_12_288) begin
      if (!i_reset_n) begin
         state          <= IDLE;
         last_granted   <= 1'b1;
         miss_cnt       <= '0;
         burst_cnt      <= '0;
         o_audio_l      <= '0;
         o_audio_r      <= '0;
         o_underrun     <= 1'b0;
         o_underrun_cnt <= '0;
      end else begin
         o_underrun <= 1'b0;
         if (i_frame) begin
            case (state)
               IDLE: begin
                  o_audio_l <= '0;
                  o_audio_r <= '0;
                  if (i_s0_valid || i_s1_valid) begin
                     state        <= idle_pick_s1 ? GRANT1 : GRANT0;
                     last_granted <= idle_pick_s1;
                     miss_cnt     <= '0;
                     burst_cnt    <= '0;
                  end
               end
               GRANT0, GRANT1: begin
                  if (owner_valid) begin
                     o_audio_l <= owner_l;
                     o_audio_r <= owner_r;
                     miss_cnt  <= '0;
                     if (burst_done) begin
                        burst_cnt <= '0;
                        if (other_valid) begin
                           state        <= owner_is_s1 ? GRANT0 : GRANT1;
                           last_granted <= ~owner_is_s1;
                        end
                     end else if (burst_cnt != 8'hFF) begin
                        burst_cnt <= burst_next[7:0];
                     end
                  end else begin
                     o_audio_l  <= '0;
                     o_audio_r  <= '0;
                     o_underrun <= 1'b1;
                     if (o_underrun_cnt != 16'hFFFF) begin
                        o_underrun_cnt <= o_underrun_cnt + 16'd1;
                     end
                     // Release always goes through IDLE, never a same-frame handover.
                     if (miss_next >= 5'(IDLE_FRAMES)) begin
                        state    <= IDLE;
                        miss_cnt <= '0;
                     end else begin
                        miss_cnt <= miss_next[3:0];
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: doc/i2s_src_arb.md
I2S_SRC_ARB -- requirements
Module: i2s_src_arb

Interface
REQ-001 Parameter DATA_BIT, default 16, sample width per channel.
REQ-002 Parameter IDLE_FRAMES, default 4, consecutive missed frames before grant release (range 1-15).
REQ-003 Parameter BURST_FRAMES, default 8, frames per grant in round-robin mode before yielding (range 1-255).
REQ-004 i_clk_12_288  in  1  sole clock.
REQ-005 i_reset_n  in  1  reset, synchronous, active-low.
REQ-006 i_frame  in  1  one-cycle pulse per I2S frame (driven from the i2s o_audio_valid strobe).
REQ-007 i_mode  in  1  0 = fixed priority (source 0 wins), 1 = round robin.
REQ-008 i_s0_valid / i_s1_valid  in  1 each  source has a stereo sample pending.
REQ-009 i_s0_l, i_s0_r, i_s1_l, i_s1_r  in  DATA_BIT each  source sample data.
REQ-010 o_s0_ready / o_s1_ready  out  1 each  sample consumed this cycle.
REQ-011 o_audio_l, o_audio_r  out  DATA_BIT each  registered sample to the i2s i_audio_l/i_audio_r.
REQ-012 o_grant  out  2  one-hot current owner; 2'b00 = none.
REQ-013 o_underrun  out  1  one-cycle pulse, owner missed a frame.
REQ-014 o_underrun_cnt  out  16  saturating count of underruns.

Function
REQ-015 FSM states: IDLE, GRANT0, GRANT1; all decisions occur only on cycles with i_frame=1; state holds otherwise.
REQ-016 Transfer occurs when o_sN_ready=1 and i_sN_valid=1; o_sN_ready = i_frame AND state=GRANTN, combinational, otherwise 0.
REQ-017 On transfer, o_audio_l/r load i_sN_l/r on the next clock edge (latency 1) and hold until the next i_frame.
REQ-018 In GRANTN at i_frame with i_sN_valid=0: o_audio_l/r load 0 (mute) next edge, o_underrun pulses 1 cycle next edge, o_underrun_cnt increments, saturating at 16'hFFFF.
REQ-019 Miss counter: cleared on transfer, incremented on underrun; underrun reaching IDLE_FRAMES consecutive -> IDLE.
REQ-020 IDLE at i_frame: outputs load 0, no ready, no underrun; if any valid, select owner and enter GRANTN; first transfer at the following i_frame.
REQ-021 Selection from IDLE, mode 0: source 0 if valid, else source 1.
REQ-022 Selection from IDLE, mode 1: the source not most recently granted if valid, else the other; last-granted register resets to source 1 (so source 0 wins first).
REQ-023 Burst counter: cleared on entering GRANTN, incremented per transfer.
REQ-024 Mode 1 only: transfer bringing burst count to BURST_FRAMES while the other source is valid -> switch directly to GRANT(other), miss and burst counters cleared; if other not valid, stay and clear burst counter.
REQ-025 Mode 0: owner keeps grant until released per REQ-019; source 0 does not preempt source 1.
REQ-026 i_mode sampled only at i_frame; a change mid-frame affects the next decision only.
REQ-027 o_grant is registered and reflects the state: IDLE=00, GRANT0=01, GRANT1=10.
REQ-028 Simultaneous release (REQ-019) and the other source valid: go to IDLE; no same-frame handover.

Reset
REQ-029 With i_reset_n=0 at an edge: state IDLE, o_audio_l/r=0, o_grant=00, o_underrun=0, o_underrun_cnt=0, miss/burst counters 0, last-granted=1.
REQ-030 i_frame is ignored while reset is asserted; reset mid-grant drops ownership without a ready pulse.

Verification
REQ-031 Mode 0, s0 valid with L=16'h1234/R=16'h5678: frame1 -> o_grant=01; frame2 -> o_s0_ready=1, o_audio_l=1234/o_audio_r=5678 one cycle later.
REQ-032 Owner s0 drops valid for 4 frames: 4 o_underrun pulses, cnt=4, audio=0, o_grant=00 after the 4th frame; 3 misses then valid -> grant kept, miss counter cleared.
REQ-033 Mode 1, BURST_FRAMES=8, both valid always: grants alternate 01/10 every 8 transfers, never an IDLE frame between them.
REQ-034 Mode 0, both valid from IDLE -> o_grant=01; s1 never ready while s0 supplies.
REQ-035 Force 65540 underruns -> o_underrun_cnt holds 16'hFFFF; reset asserted mid-GRANT1 -> all outputs zero next edge.
